// File: rtl/roi_color_averager_pkg.sv
// Shared types and channel-select codes for the ROI colour averager.
package roi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    UPDATE
  } roi_state_t;

  localparam int unsigned CH_R    = 0;
  localparam int unsigned CH_G    = 1;
  localparam int unsigned CH_B    = 2;
  localparam int unsigned CH_LUMA = 3;

endpackage

// File: rtl/roi_color_averager_div_seq.sv
// Restoring divider producing one quotient bit per cycle; quotient holds after done.
module div_seq #(
  parameter int unsigned N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     rem;
  logic [N-1:0]     quo;
  logic [N-1:0]     dsr;
  logic [IDX_W-1:0] idx;
  logic [N:0]       shifted;
  logic [N:0]       diff;
  logic             ge;

  // quo doubles as the dividend shift register: its MSB feeds the remainder each step
  always_comb begin
    shifted = {rem, quo[N-1]};
    ge      = (shifted >= {1'b0, dsr});
    diff    = shifted - {1'b0, dsr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
      idx  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        rem  <= '0;
        quo  <= dividend;
        dsr  <= divisor;
        idx  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge ? diff[N-1:0] : shifted[N-1:0];
        quo <= {quo[N-2:0], ge};
        idx <= idx + 1'b1;
        if (idx == IDX_W'(N - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/roi_color_averager.sv
// ROI overlay on the VGA pixel path plus per-frame channel averaging with a
// hysteresis-filtered detection flag.
module roi_color_averager
  import roi_pkg::*;
#(
  parameter int unsigned          COORD_W   = 10,
  parameter int unsigned          CH_W      = 8,
  parameter int unsigned          X_MIN     = 270,
  parameter int unsigned          X_MAX     = 370,
  parameter int unsigned          Y_MIN     = 160,
  parameter int unsigned          Y_MAX     = 320,
  parameter int unsigned          BORDER    = 4,
  parameter logic [3*CH_W-1:0]    BOX_RGB   = 24'h00FF00,
  parameter int unsigned          CHANNEL   = 0,
  parameter int unsigned          ACC_W     = 24,
  parameter int unsigned          CNT_W     = 16,
  parameter int unsigned          THRESH_HI = 128,
  parameter int unsigned          THRESH_LO = 112
) (
  input  logic               Clk,
  input  logic               RST,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [CH_W-1:0]    vga_r,
  input  logic [CH_W-1:0]    vga_g,
  input  logic [CH_W-1:0]    vga_b,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_r,
  output logic [CH_W-1:0]    out_g,
  output logic [CH_W-1:0]    out_b,
  output logic [CH_W-1:0]    avg_value,
  output logic               avg_valid,
  output logic               move_signal
);

  localparam int unsigned ACC_NEED = CH_W + $clog2((X_MAX - X_MIN) * (Y_MAX - Y_MIN));

  if (THRESH_LO > THRESH_HI) begin : g_bad_thresh
    $error("roi_color_averager: THRESH_LO must not exceed THRESH_HI");
  end
  if ((X_MIN < BORDER) || (Y_MIN < BORDER)) begin : g_bad_border
    $error("roi_color_averager: ROI too close to origin for BORDER");
  end
  if (ACC_W < ACC_NEED) begin : g_bad_acc
    $error("roi_color_averager: ACC_W too small for ROI area");
  end

  localparam logic [COORD_W-1:0] XI_LO = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] XI_HI = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YI_LO = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YI_HI = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] XO_LO = COORD_W'(X_MIN - BORDER);
  localparam logic [COORD_W-1:0] XO_HI = COORD_W'(X_MAX + BORDER);
  localparam logic [COORD_W-1:0] YO_LO = COORD_W'(Y_MIN - BORDER);
  localparam logic [COORD_W-1:0] YO_HI = COORD_W'(Y_MAX + BORDER);
  localparam logic [CH_W-1:0]    TH_HI = CH_W'(THRESH_HI);
  localparam logic [CH_W-1:0]    TH_LO = CH_W'(THRESH_LO);

  roi_state_t state, state_next;

  logic              interior;
  logic              outer;
  logic              box_on;
  logic              last_pix;
  logic              accept;
  logic [CH_W+1:0]   luma_sum;
  logic [CH_W-1:0]   sample;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [ACC_W-1:0]  quotient;
  logic [CH_W-1:0]   q_sat;
  logic              avg_load;

  always_comb begin
    interior = (draw_x >= XI_LO) && (draw_x < XI_HI) && (draw_y >= YI_LO) && (draw_y < YI_HI);
    outer    = (draw_x >= XO_LO) && (draw_x < XO_HI) && (draw_y >= YO_LO) && (draw_y < YO_HI);
    box_on   = outer && !interior;
    last_pix = (draw_x == XI_HI - 1'b1) && (draw_y == YI_HI - 1'b1);
  end

  always_comb begin
    luma_sum = {2'b00, vga_r} + {1'b0, vga_g, 1'b0} + {2'b00, vga_b};
    case (CHANNEL)
      CH_R:    sample = vga_r;
      CH_G:    sample = vga_g;
      CH_B:    sample = vga_b;
      default: sample = luma_sum[CH_W+1:2];
    endcase
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      out_valid <= pix_valid;
      if (box_on) begin
        {out_r, out_g, out_b} <= BOX_RGB;
      end else begin
        {out_r, out_g, out_b} <= {vga_r, vga_g, vga_b};
      end
    end
  end

  assign accept = (state == ACCUM) && pix_valid && interior && !frame_start;

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = ACCUM;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ACCUM:   if (accept && last_pix) state_next = DIVIDE;
        DIVIDE: begin
          if (cnt == '0)    state_next = IDLE;
          else if (div_done) state_next = UPDATE;
        end
        UPDATE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The result registers load on the DIVIDE->UPDATE edge, so avg_valid (high
  // throughout UPDATE) always coincides with the freshly loaded avg_value.
  always_comb begin
    div_start = 1'b0;
    avg_load  = 1'b0;
    avg_valid = 1'b0;
    case (state)
      DIVIDE: begin
        div_start = !frame_start && (cnt != '0) && !div_busy && !div_done;
        avg_load  = !frame_start && div_done;
      end
      UPDATE:  avg_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      acc <= '0;
      cnt <= '0;
    end else if (frame_start) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc + ACC_W'(sample);
      if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  div_seq #(
    .N(ACC_W)
  ) u_div (
    .clk      (Clk),
    .rst      (RST),
    .start    (div_start),
    .abort    (frame_start),
    .dividend (acc),
    .divisor  (ACC_W'(cnt)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  assign q_sat = (|quotient[ACC_W-1:CH_W]) ? '1 : quotient[CH_W-1:0];

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      avg_value   <= '0;
      move_signal <= 1'b0;
    end else if (avg_load) begin
      avg_value <= q_sat;
      if (q_sat >= TH_HI) begin
        move_signal <= 1'b1;
      end else if (q_sat < TH_LO) begin
        move_signal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_roi_color_averager.sv
// Directed bench: overlay vector table, frame-average table, and hand-written
// abort / reset sequences on a red-channel and a luma instance.
`timescale 1ns/1ps
module tb_roi_color_averager;

  localparam int X_MIN = 270;
  localparam int X_MAX = 370;
  localparam int Y_MIN = 160;
  localparam int Y_MAX = 320;
  localparam int LAT   = 1 + 24 + 1;

  logic       Clk = 1'b0;
  logic       RST;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] draw_x, draw_y;
  logic [7:0] vga_r, vga_g, vga_b;

  logic       ov0, ov3;
  logic [7:0] or0, og0, ob0, or3, og3, ob3;
  logic [7:0] avg0, avg3;
  logic       av0, av3, mv0, mv3;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses3 = 0;

  always #5 Clk = ~Clk;

  roi_color_averager #(.CHANNEL(0)) dut0 (
    .Clk(Clk), .RST(RST), .frame_start(frame_start), .pix_valid(pix_valid),
    .draw_x(draw_x), .draw_y(draw_y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .out_valid(ov0), .out_r(or0), .out_g(og0), .out_b(ob0),
    .avg_value(avg0), .avg_valid(av0), .move_signal(mv0)
  );

  roi_color_averager #(.CHANNEL(3)) dut3 (
    .Clk(Clk), .RST(RST), .frame_start(frame_start), .pix_valid(pix_valid),
    .draw_x(draw_x), .draw_y(draw_y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .out_valid(ov3), .out_r(or3), .out_g(og3), .out_b(ob3),
    .avg_value(avg3), .avg_valid(av3), .move_signal(mv3)
  );

  always @(posedge Clk) begin
    if (av0) pulses0++;
    if (av3) pulses3++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    int x, y, r, g, b;
    bit v;
    int er, eg, eb;
    bit ev;
  } ov_vec_t;

  typedef struct {
    int r, g, b, stride;
    bit half;
    int avg0;
    bit mv0;
    int avg3;
    bit mv3;
  } fr_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int r, input int g, input int b, input bit v);
    @(negedge Clk);
    frame_start = 1'b0;
    pix_valid   = v;
    draw_x      = 10'(x);
    draw_y      = 10'(y);
    vga_r       = 8'(r);
    vga_g       = 8'(g);
    vga_b       = 8'(b);
  endtask

  task automatic pulse_frame_start();
    @(negedge Clk);
    frame_start = 1'b1;
    pix_valid   = 1'b0;
  endtask

  // Interior pixels on a column stride (last pixel always included); sparse
  // frames also carry bright valid pixels just outside the interior.
  task automatic send_frame(input int r, input int g, input int b, input int stride, input bit half);
    int idx;
    bit last;
    idx = 0;
    pulse_frame_start();
    if (stride > 1) drive(300, Y_MIN - 1, 255, 255, 255, 1'b1);
    for (int y = Y_MIN; y < Y_MAX; y++) begin
      if (stride > 1) drive(X_MIN - 1, y, 255, 255, 255, 1'b1);
      for (int x = X_MIN; x < X_MAX; x += stride) begin
        last = (x == X_MAX - 1) && (y == Y_MAX - 1);
        if (half && !last && idx[0]) drive(x, y, 255, 255, 255, 1'b0);
        else drive(x, y, r, g, b, 1'b1);
        idx++;
      end
      if (((X_MAX - 1 - X_MIN) % stride) != 0) drive(X_MAX - 1, y, r, g, b, 1'b1);
      if (stride > 1 && y != Y_MAX - 1) drive(X_MAX, y, 255, 255, 255, 1'b1);
    end
  endtask

  task automatic run_frame(input fr_vec_t v, input string tag);
    int p0, p3, lat;
    p0  = pulses0;
    p3  = pulses3;
    lat = -1;
    send_frame(v.r, v.g, v.b, v.stride, v.half);
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clk);
      if (k == 1) pix_valid = 1'b0;
      if (av0) begin
        lat = k - 1;
        break;
      end
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_valid3"}, av3, 1);
    check({tag, "_avg0"}, avg0, v.avg0);
    check({tag, "_move0"}, mv0, v.mv0);
    check({tag, "_avg3"}, avg3, v.avg3);
    check({tag, "_move3"}, mv3, v.mv3);
    repeat (5) @(negedge Clk);
    check({tag, "_pulses0"}, pulses0 - p0, 1);
    check({tag, "_pulses3"}, pulses3 - p3, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, ov0, 0);
    check({tag, "_out_r"}, or0, 0);
    check({tag, "_out_g"}, og0, 0);
    check({tag, "_out_b"}, ob0, 0);
    check({tag, "_avg_value"}, avg0, 0);
    check({tag, "_avg_valid"}, av0, 0);
    check({tag, "_move"}, mv0, 0);
    check({tag, "_move3"}, mv3, 0);
  endtask

  ov_vec_t ov_tab[9];
  fr_vec_t fr_tab[6];

  initial begin
    int p0;
    fr_vec_t f;

    ov_tab[0] = '{266, 200, 12, 34, 56, 1'b1,   0, 255,  0, 1'b1};
    ov_tab[1] = '{270, 200, 12, 34, 56, 1'b1,  12,  34, 56, 1'b1};
    ov_tab[2] = '{375, 200,  1,  2,  3, 1'b1,   1,   2,  3, 1'b1};
    ov_tab[3] = '{373, 200,  9,  9,  9, 1'b1,   0, 255,  0, 1'b1};
    ov_tab[4] = '{265, 200,  4,  5,  6, 1'b1,   4,   5,  6, 1'b1};
    ov_tab[5] = '{300, 156, 70, 80, 90, 1'b1,   0, 255,  0, 1'b1};
    ov_tab[6] = '{300, 155, 70, 80, 90, 1'b1,  70,  80, 90, 1'b1};
    ov_tab[7] = '{300, 323, 11, 22, 33, 1'b1,   0, 255,  0, 1'b1};
    ov_tab[8] = '{300, 200,  7,  8,  9, 1'b0,   7,   8,  9, 1'b0};

    fr_tab[0] = '{200,   0,   0, 1, 1'b0, 200, 1'b1,  50, 1'b0};
    fr_tab[1] = '{120,   0,   0, 5, 1'b0, 120, 1'b1,  30, 1'b0};
    fr_tab[2] = '{100,   0,   0, 5, 1'b0, 100, 1'b0,  25, 1'b0};
    fr_tab[3] = '{ 40, 100,  60, 5, 1'b0,  40, 1'b0,  75, 1'b0};
    fr_tab[4] = '{200, 200, 200, 5, 1'b0, 200, 1'b1, 200, 1'b1};
    fr_tab[5] = '{ 50,  50,  50, 5, 1'b1,  50, 1'b0,  50, 1'b0};

    RST = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    draw_x = '0; draw_y = '0; vga_r = '0; vga_g = '0; vga_b = '0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(ov_tab[i].x, ov_tab[i].y, ov_tab[i].r, ov_tab[i].g, ov_tab[i].b, ov_tab[i].v);
      @(negedge Clk);
      check($sformatf("ov%0d_valid", i), ov0, ov_tab[i].ev);
      check($sformatf("ov%0d_r", i), or0, ov_tab[i].er);
      check($sformatf("ov%0d_g", i), og0, ov_tab[i].eg);
      check($sformatf("ov%0d_b", i), ob0, ov_tab[i].eb);
      check($sformatf("ov%0d_luma_inst_g", i), og3, ov_tab[i].eg);
    end
    check("ov_no_avg_while_idle", pulses0, 0);

    for (int i = 0; i < 6; i++) run_frame(fr_tab[i], $sformatf("frame%0d", i));

    // frame_start lands mid-divide: the aborted frame must never report
    p0 = pulses0;
    send_frame(77, 0, 0, 5, 1'b0);
    repeat (5) @(negedge Clk);
    pix_valid = 1'b0;
    f = '{10, 0, 0, 5, 1'b0, 10, 1'b0, 2, 1'b0};
    run_frame(f, "after_abort");
    check("abort_total_pulses", pulses0 - p0, 1);

    f = '{200, 200, 200, 5, 1'b0, 200, 1'b1, 200, 1'b1};
    run_frame(f, "pre_reset");

    // reset while accumulating, with a live overlay pixel in the output register
    pulse_frame_start();
    for (int x = X_MIN; x < X_MIN + 20; x++) drive(x, Y_MIN, 255, 255, 255, 1'b1);
    drive(266, 200, 1, 2, 3, 1'b1);
    @(negedge Clk);
    check("pre_rst_out_g", og0, 255);
    check("pre_rst_move", mv0, 1);
    #2 RST = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge Clk);
    RST = 1'b0;
    p0 = pulses0;
    for (int x = X_MAX - 10; x < X_MAX; x++) drive(x, Y_MAX - 1, 255, 255, 255, 1'b1);
    drive(0, 0, 0, 0, 0, 1'b0);
    repeat (40) @(negedge Clk);
    check("post_rst_no_avg", pulses0 - p0, 0);
    check("post_rst_avg_hold", avg0, 0);

    f = '{130, 130, 130, 5, 1'b0, 130, 1'b1, 130, 1'b1};
    run_frame(f, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
